// File: rtl/mag_cmp_serial_pkg.sv
// Types and constants for mag_cmp_serial, built on mag_cmp_defs.vh.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mag_cmp_serial_pkg;

`include "mag_cmp_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `MAG_CMP_ST_IDLE,
    ST_RUN  = `MAG_CMP_ST_RUN,
    ST_DONE = `MAG_CMP_ST_DONE
  } state_t;

  // One-hot result, bit order {lt, eq, gt}
  typedef logic [2:0] res_t;

  localparam res_t RES_NONE = `MAG_CMP_RES_NONE;
  localparam res_t RES_LT   = `MAG_CMP_RES_LT;
  localparam res_t RES_EQ   = `MAG_CMP_RES_EQ;
  localparam res_t RES_GT   = `MAG_CMP_RES_GT;

  // Map a slice compare outcome onto a result code
  function automatic res_t slice_res(input logic gt, input logic lt);
    if (gt) begin
      return RES_GT;
    end else if (lt) begin
      return RES_LT;
    end
    return RES_EQ;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// 2-bit unsigned slice comparator: gt = a>b, lt = a<b (both 0 when equal).
// Latency: combinational.
// Backpressure: none.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_defs.vh
// Shared encodings for the serial magnitude comparator.
// FSM state codes and one-hot result codes, ordered {lt, eq, gt}.
// Guarded so the RTL package and the bench can both pull it in.
`ifndef MAG_CMP_DEFS_VH
`define MAG_CMP_DEFS_VH

`define MAG_CMP_ST_IDLE 2'd0
`define MAG_CMP_ST_RUN  2'd1
`define MAG_CMP_ST_DONE 2'd2

`define MAG_CMP_RES_NONE 3'b000
`define MAG_CMP_RES_LT   3'b100
`define MAG_CMP_RES_EQ   3'b010
`define MAG_CMP_RES_GT   3'b001

`endif

// File: rtl/mag_cmp_serial.sv
// Serial unsigned magnitude compare, 2 bits per cycle MSB first; optional MAG_CMP_EARLY_EXIT_EN.
// Latency: W/2 cycles from acceptance to out_valid (k+1 on first differing slice k with early exit).
// Backpressure: holds DONE until out_ready; accepts new operands only in IDLE.
module mag_cmp_serial
  import mag_cmp_serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  localparam int NSLICE = W / 2;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  res_t             res_q, res_d;

  logic sl_gt, sl_lt, sl_diff;
  logic last_slice, run_exit;

  // Top two bits of each shift register are the slice under test this cycle
  cmp2_slice u_slice (
    .a  (a_sh_q[W-1 -: 2]),
    .b  (b_sh_q[W-1 -: 2]),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  assign sl_diff    = sl_gt | sl_lt;
  assign last_slice = (idx_q == LAST_IDX);

  // Next-state: accept in IDLE, walk slices in RUN, wait for consumer in DONE
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    idx_d    = idx_q;
    res_d    = res_q;
    run_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          idx_d   = '0;
          res_d   = RES_EQ;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q << 2;
        b_sh_d = b_sh_q << 2;
        idx_d  = idx_q + 1'b1;
        // Only the first differing slice decides; later slices are ignored
        if ((res_q == RES_EQ) && sl_diff) begin
          res_d = slice_res(sl_gt, sl_lt);
        end
`ifdef MAG_CMP_EARLY_EXIT_EN
        run_exit = last_slice || sl_diff;
`else
        run_exit = last_slice;
`endif
        if (run_exit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Returning to IDLE here means no acceptance on the handshake edge
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign {lt, eq, gt}  = out_valid ? res_q : RES_NONE;

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Directed scoreboard bench for mag_cmp_serial with W=8.
// Latency expectations follow MAG_CMP_EARLY_EXIT_EN when it is defined.
// Stimulus pushes expected results; a negedge monitor pops and compares.
`include "mag_cmp_defs.vh"

module tb_mag_cmp_serial;

  localparam int W = 8;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, lt, eq, gt;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   n_acc = 0;
  int   n_issue = 0;
  logic prev_ov = 1'b0;
  logic [2:0] held = '0;
  exp_t sb[$];
  exp_t e_pop;

  logic [7:0] bb_a [4];
  logic [7:0] bb_b [4];
  logic [2:0] bb_r [4];
  int         bb_lf[4];
  int         bb_le[4];

  mag_cmp_serial #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input int full, input int early);
`ifdef MAG_CMP_EARLY_EXIT_EN
    return early;
`else
    return full;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("wait_out_valid", {31'd0, out_valid}, 1);
  endtask

  task automatic wait_ir();
    for (int i = 0; i < 20 && !in_ready; i++) step();
    chk("wait_in_ready", {31'd0, in_ready}, 1);
  endtask

  // One operation with optional out_ready stall of 'hold' cycles once out_valid is up
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] r,
                        input int lf, input int le, input int hold);
    exp_t e;
    chk("in_ready_before", {31'd0, in_ready}, 1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    e.res = r;
    e.lat = exp_lat(lf, le);
    sb.push_back(e);
    n_issue++;
    step();
    in_valid = 1'b0;
    a = ~va;
    b = ~vb;
    chk("in_ready_busy", {31'd0, in_ready}, 0);
    wait_ov();
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_in_ready", {31'd0, in_ready}, 1);
    chk("post_hs_out_valid", {31'd0, out_valid}, 0);
  endtask

  // Monitor: counts acceptances, checks each new result against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_edge = cyc + 1;
        n_acc++;
      end
      if (out_valid) begin
        if (!prev_ov) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got %b with no expected entry (cycle %0d)", {lt, eq, gt}, cyc);
          end else begin
            e_pop = sb.pop_front();
            chk("result", {29'd0, lt, eq, gt}, {29'd0, e_pop.res});
            chk("latency", 32'(cyc - acc_edge), 32'(e_pop.lat));
          end
          held = {lt, eq, gt};
        end else begin
          chk("hold_stable", {29'd0, lt, eq, gt}, {29'd0, held});
        end
        chk("onehot", 32'($countones({lt, eq, gt})), 1);
      end else begin
        chk("idle_results_zero", {29'd0, lt, eq, gt}, 0);
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bb_a[0] = 8'hA5; bb_b[0] = 8'hA6; bb_r[0] = `MAG_CMP_RES_LT; bb_lf[0] = 4; bb_le[0] = 4;
    bb_a[1] = 8'h3C; bb_b[1] = 8'h0F; bb_r[1] = `MAG_CMP_RES_GT; bb_lf[1] = 4; bb_le[1] = 2;
    bb_a[2] = 8'hFF; bb_b[2] = 8'hFF; bb_r[2] = `MAG_CMP_RES_EQ; bb_lf[2] = 4; bb_le[2] = 4;
    bb_a[3] = 8'h40; bb_b[3] = 8'h80; bb_r[3] = `MAG_CMP_RES_LT; bb_lf[3] = 4; bb_le[3] = 1;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_results", {29'd0, lt, eq, gt}, 0);
    reset = 1'b0;
    step();
    step();
    chk("idle_stays_idle", {31'd0, in_ready}, 1);

    // Directed single operations
    run_op(8'h5A, 8'h5A, `MAG_CMP_RES_EQ, 4, 4, 0);
    run_op(8'h80, 8'h7F, `MAG_CMP_RES_GT, 4, 1, 0);
    run_op(8'h12, 8'h13, `MAG_CMP_RES_LT, 4, 4, 0);
    run_op(8'hC3, 8'hC1, `MAG_CMP_RES_GT, 4, 4, 0);
    run_op(8'h00, 8'hFF, `MAG_CMP_RES_LT, 4, 1, 10);

    // Reset two cycles after acceptance discards the operation
    a = 8'hC0;
    b = 8'h40;
    in_valid = 1'b1;
    n_issue++;
`ifdef MAG_CMP_EARLY_EXIT_EN
    // First slice differs, so this one reaches DONE before the reset lands
    e.res = `MAG_CMP_RES_GT;
    e.lat = 1;
    sb.push_back(e);
`endif
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_results", {29'd0, lt, eq, gt}, 0);
    step();
    reset = 1'b0;
    run_op(8'h01, 8'h02, `MAG_CMP_RES_LT, 4, 4, 0);

    // Back-to-back with in_valid held high and operands scrambled after acceptance
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_ir();
      a = bb_a[j];
      b = bb_b[j];
      e.res = bb_r[j];
      e.lat = exp_lat(bb_lf[j], bb_le[j]);
      sb.push_back(e);
      n_issue++;
      step();
      a = ~bb_a[j];
      b = bb_b[j] ^ 8'h5A;
      chk("b2b_busy", {31'd0, in_ready}, 0);
    end
    wait_ir();
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    chk("sb_drained", 32'(sb.size()), 0);
    chk("accept_count", 32'(n_acc), 32'(n_issue));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mag_cmp_serial.md
MAG_CMP_SERIAL -- requirements
Module: mag_cmp_serial

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the unsigned operand width; W SHALL be even and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, the asynchronous, active-high reset.
REQ-004 The block SHALL have port a, input, W bits, the first unsigned operand, sampled at acceptance.
REQ-005 The block SHALL have port b, input, W bits, the second unsigned operand, sampled at acceptance.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning a/b are presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-010 The block SHALL have ports lt, eq and gt, outputs, 1 bit each, giving the one-hot result a<b, a==b or a>b.

Function
REQ-011 The block SHALL use a 3-state FSM: IDLE, RUN and DONE.
REQ-012 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-013 On a clock edge with in_valid=1 in IDLE (acceptance), the block SHALL load a and b into shift registers, clear the slice index and enter RUN; with in_valid=0 it SHALL stay in IDLE.
REQ-014 Each RUN cycle SHALL compare the top 2 bits of both shift registers (MSB first) with one 2-bit slice comparator, then shift both registers left by 2.
REQ-015 The first slice with a != b SHALL fix the result; all later slices SHALL NOT change it; if no slice differs, the result SHALL be eq.
REQ-016 RUN SHALL exit to DONE on the edge that processes slice W/2-1, giving out_valid exactly W/2 cycles after the acceptance edge; early exit is covered by REQ-024.
REQ-017 In DONE, out_valid SHALL be 1 and lt/eq/gt SHALL hold exactly one asserted bit, stable until the handshake completes.
REQ-018 When out_valid and out_ready are both 1 on an edge, the block SHALL return to IDLE; with out_ready=0 it SHALL hold DONE indefinitely.
REQ-019 Operands SHALL NOT be accepted on the edge that completes the output handshake; in_ready rises the following cycle (minimum issue interval W/2+2 cycles).
REQ-020 Outside DONE, out_valid, lt, eq and gt SHALL all be 0.
REQ-021 Changes on a/b after acceptance SHALL NOT affect the result in progress.

Reset
REQ-022 Asserting reset at any time, including mid-RUN or in DONE, SHALL immediately force IDLE, discard the operation, clear the shift registers and index, and drive in_ready=1, out_valid=0, lt=0, eq=0, gt=0.
REQ-023 After reset deasserts, the first acceptance SHALL be possible on the next rising edge with in_valid=1.

Configuration
REQ-024 With macro MAG_CMP_EARLY_EXIT_EN defined, RUN SHALL exit to DONE on the edge processing the first differing slice k (0-based from MSB), so out_valid rises k+1 cycles after acceptance; equal operands still take W/2 cycles.
REQ-025 Without MAG_CMP_EARLY_EXIT_EN, latency SHALL always be W/2 cycles, independent of the data.

Structure
REQ-026 The FSM state encodings and the result codes (LT/EQ/GT) SHALL live in a shared include file, mag_cmp_defs.vh, used by both RTL and bench.
REQ-027 The per-cycle slice compare SHALL be a sub-module, cmp2_slice: combinational, 2-bit a/b in, gt/lt out.

Verification
REQ-028 The bench SHALL cover these directed scenarios with W=8:
- a=0x5A, b=0x5A -> eq=1 with out_valid 4 cycles after acceptance, in both builds.
- a=0x80, b=0x7F -> gt=1; out_valid after 1 cycle with MAG_CMP_EARLY_EXIT_EN, after 4 cycles without.
- a=0x12, b=0x13 -> lt=1; out_valid after 4 cycles in both builds, since only the last slice differs.
- a=0x00, b=0xFF with out_ready=0 for 10 cycles -> lt=1 and out_valid held stable, in_ready=0 throughout; then out_ready=1 -> IDLE, with in_ready=1 the next cycle.
- reset pulsed 2 cycles after accepting a=0xC0, b=0x40 -> all outputs reset immediately; a new operation a=0x01, b=0x02 then yields lt=1.
- back-to-back operations with in_valid held at 1 -> each accepted only in IDLE, and the changing a/b after acceptance do not corrupt results.
